// File: rtl/mux_sched_pkg.sv
// Shared definitions for the round-robin mux scheduler: requester count,
// select width, FSM state type and a select-to-one-hot helper.
package mux_sched_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

    // Expand a requester index into its one-hot grant/ack pattern.
    function automatic logic [N_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        logic [N_REQ-1:0] base;
        base = {{(N_REQ-1){1'b0}}, 1'b1};
        return base << sel;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// Rotated first-one search over 16 requesters. The search starts at
// last_ptr+1 and wraps 15->0, so the previous winner has lowest priority.
// Purely combinational.
module rr_pick16
    import mux_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last_ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand_s;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        found  = 1'b0;
        idx    = {SEL_W{1'b0}};
        cand_s = {SEL_W{1'b0}};
        for (int i = N_REQ; i >= 1; i--) begin
            // Offset 16 wraps back to last_ptr itself (lowest priority).
            cand_s = last_ptr + SEL_W'(i);
            if (req[cand_s]) begin
                found = 1'b1;
                idx   = cand_s;
            end else begin
                found = found;
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler in front of a shared 16:1 x 8-bit data mux.
// Arbitrates req, drives mux_sel/grant, qualifies the muxed beat with
// out_valid/out_ready and pulses a one-hot ack on every accepted beat.
// Optional feature macro: ARB_BURST_EN -- when defined, a granted requester
// may keep the grant for up to MAX_BURST consecutive accepted beats;
// otherwise every grant carries exactly one beat.
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             out_ready,
    output logic [SEL_W-1:0] mux_sel,
    output logic [N_REQ-1:0] grant,
    output logic             out_valid,
    output logic [N_REQ-1:0] ack,
    output logic             busy
);

    if ((MAX_BURST < 1) || (MAX_BURST > 16)) begin : g_bad_max_burst
        $error("mux_rr_scheduler: MAX_BURST must lie in 1..16");
    end

    sched_state_t     state_q;
    logic [N_REQ-1:0] grant_q;
    logic [SEL_W-1:0] mux_sel_q;
    logic [SEL_W-1:0] last_ptr_q;

    logic             pick_found_s;
    logic [SEL_W-1:0] pick_idx_s;
    logic             out_valid_s;
    logic             xfer_s;
    logic [N_REQ-1:0] ack_s;
    logic             end_of_grant_s;

`ifdef ARB_BURST_EN
    localparam logic [3:0] BURST_LAST_BEAT = 4'(MAX_BURST - 1);
    logic [3:0] beat_cnt_q;

    assign end_of_grant_s = (beat_cnt_q == BURST_LAST_BEAT);
`else
    assign end_of_grant_s = 1'b1;
`endif

    rr_pick16 u_pick (
        .req      (req),
        .last_ptr (last_ptr_q),
        .found    (pick_found_s),
        .idx      (pick_idx_s)
    );

    // Beat qualification: valid follows the granted request; ack mirrors a transfer.
    always_comb begin
        out_valid_s = 1'b0;
        xfer_s      = 1'b0;
        ack_s       = {N_REQ{1'b0}};
        if (state_q == GRANT) begin
            out_valid_s = req[mux_sel_q];
        end else begin
            out_valid_s = 1'b0;
        end
        xfer_s = out_valid_s & out_ready;
        if (xfer_s) begin
            ack_s = sel_to_onehot(mux_sel_q);
        end else begin
            ack_s = {N_REQ{1'b0}};
        end
    end

    // Scheduler FSM: arbitration, grant/select registers, pointer and beat count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= {N_REQ{1'b0}};
            mux_sel_q  <= {SEL_W{1'b0}};
            last_ptr_q <= 4'hF;
`ifdef ARB_BURST_EN
            beat_cnt_q <= 4'h0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found_s) begin
                        mux_sel_q  <= pick_idx_s;
                        grant_q    <= sel_to_onehot(pick_idx_s);
`ifdef ARB_BURST_EN
                        beat_cnt_q <= 4'h0;
`endif
                        state_q    <= GRANT;
                    end else begin
                        state_q    <= IDLE;
                    end
                end
                GRANT: begin
                    if (!req[mux_sel_q]) begin
                        // Requester withdrew: give up the grant without an ack.
                        last_ptr_q <= mux_sel_q;
                        grant_q    <= {N_REQ{1'b0}};
                        state_q    <= IDLE;
                    end else if (xfer_s) begin
                        if (end_of_grant_s) begin
                            last_ptr_q <= mux_sel_q;
                            grant_q    <= {N_REQ{1'b0}};
                            state_q    <= IDLE;
                        end else begin
`ifdef ARB_BURST_EN
                            beat_cnt_q <= beat_cnt_q + 4'h1;
`endif
                            state_q    <= GRANT;
                        end
                    end else begin
                        // Downstream stall: hold the grant indefinitely.
                        state_q <= GRANT;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= {N_REQ{1'b0}};
                end
            endcase
        end
    end

    assign mux_sel   = mux_sel_q;
    assign grant     = grant_q;
    assign out_valid = out_valid_s;
    assign ack       = ack_s;
    assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Self-checking bench for mux_rr_scheduler. A requester-level reference
// model predicts grants and accepted beats; expected acks go through a
// scoreboard queue that an independent monitor drains. Honours ARB_BURST_EN.
module tb_mux_rr_scheduler;

    localparam int TB_BURST = 4;

    logic        clk;
    logic        reset_n;
    logic [15:0] req;
    logic        out_ready;
    logic [3:0]  mux_sel;
    logic [15:0] grant;
    logic        out_valid;
    logic [15:0] ack;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    mux_rr_scheduler #(.MAX_BURST(TB_BURST)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .out_ready (out_ready),
        .mux_sel   (mux_sel),
        .grant     (grant),
        .out_valid (out_valid),
        .ack       (ack),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model state: owner = requester holding the grant (-1 when idle).
    int          owner;
    int          last;
    int          beats;
    int          limit;
    logic [3:0]  exp_sel;

    initial begin
`ifdef ARB_BURST_EN
        limit = TB_BURST;
`else
        limit = 1;
`endif
        owner   = -1;
        last    = 15;
        beats   = 0;
        exp_sel = 4'h0;
    end

    // Model: compare this cycle's outputs, predict transfers, then advance.
    always @(negedge clk) begin : model
        logic [15:0] one16;
        logic [15:0] eg;
        logic        ev;
        int          c;
        logic        hit;
        one16 = 16'h0001;
        if (!reset_n) begin
            owner   = -1;
            last    = 15;
            beats   = 0;
            exp_sel = 4'h0;
        end
        eg = (owner >= 0) ? (one16 << owner) : 16'h0000;
        ev = (owner >= 0) ? req[owner] : 1'b0;
        check("grant",     grant, eg);
        check("mux_sel",   {12'h000, mux_sel}, {12'h000, exp_sel});
        check("out_valid", {15'h0000, out_valid}, {15'h0000, ev});
        check("busy",      {15'h0000, busy}, {15'h0000, (owner >= 0)});
        if (reset_n) begin
            if (owner < 0) begin
                hit = 1'b0;
                for (int k = 1; k <= 16; k++) begin
                    c = (last + k) % 16;
                    if (!hit && req[c]) begin
                        hit   = 1'b1;
                        owner = c;
                    end
                end
                if (hit) begin
                    exp_sel = 4'(owner);
                    beats   = 0;
                end
            end else if (!req[owner]) begin
                last  = owner;
                owner = -1;
            end else if (out_ready) begin
                exp_q.push_back(owner);
                beats++;
                if (beats == limit) begin
                    last  = owner;
                    owner = -1;
                end
            end
        end
    end

    // Monitor: whenever an ack appears (or one is owed), pop and compare.
    always @(negedge clk) begin : monitor
        int          e;
        logic [15:0] one16;
        one16 = 16'h0001;
        #1;
        if (ack !== 16'h0000 || exp_q.size() > 0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL ack_unexpected at %0t: got %h expected 0000", $time, ack);
            end else begin
                e = exp_q.pop_front();
                check("ack", ack, one16 << e);
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        req       = 16'h8001;
        out_ready = 1'b1;
        step(3);
        reset_n = 1'b1;
        step(6);
        req = 16'h0000;
        step(3);

        // All requesters held: strict rotation with an idle cycle between grants.
        req       = 16'hFFFF;
        out_ready = 1'b1;
        step(40);
        req = 16'h0000;
        step(3);

        // Downstream stall on requester 5, then release for one beat.
        req       = 16'h0020;
        out_ready = 1'b0;
        step(12);
        out_ready = 1'b1;
        step(1);
        req = 16'h0000;
        step(3);

        // Requester 7 withdraws before the beat is accepted; 8 wins next.
        req       = 16'h0080;
        out_ready = 1'b0;
        step(3);
        req = 16'h0000;
        step(1);
        req       = 16'h0180;
        out_ready = 1'b1;
        step(4);
        req = 16'h0000;
        step(3);

        // Asynchronous reset in the middle of requester 2's grant.
        req       = 16'h0004;
        out_ready = 1'b1;
        step(3);
        #3;
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        req     = 16'hFFFF;
        step(3);
        req = 16'h0000;
        step(3);

        // Randomised traffic with random back-pressure and withdrawals.
        repeat (1500) begin
            req       = 16'($urandom) & 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        req       = 16'h0000;
        out_ready = 1'b1;
        step(4);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ack_missing: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
